multiword_adder_ctrl: RTL and testbench
=======================================

Name: multiword_adder_ctrl

Overview:
- Sequencer that performs a WORDS x 16-bit multi-precision addition using a single shared 16-bit add-with-carry datapath, one word per clock.
- Carry is chained between words through a carry register; the least significant word is processed first.
- Sits above the 16-bit adder family in the lab datapath. Lets one narrow adder serve wide operands, trading latency for area.
- Start/Busy/Done handshake toward the host logic.

Parameters:
- WORDS, 4, number of 16-bit words per operand (legal range 2..16; operand width = 16*WORDS).

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request a new operation; sampled only in IDLE.
- Sub  input  1  subtract select; latched with Start (see Optional Feature).
- A  input  16*WORDS  operand A; latched on Start acceptance.
- B  input  16*WORDS  operand B; latched on Start acceptance.
- Sum  output  16*WORDS  registered result.
- CO  output  1  registered carry-out of the most significant word.
- Busy  output  1  high in ADD and DONE.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, word index=0, carry reg=0, operand regs=0, internal accumulator=0, Sum=0, CO=0, Busy=0, Done=0. Reset overrides every other input in the same cycle.
- States: IDLE, ADD, DONE. Encoding is free.
- IDLE:
  - Busy=0, Done=0.
  - On an edge with Start=1: latch A, B and Sub; set index=0; set carry reg=0 (or 1 for a subtract, see Optional Feature); go to ADD.
- ADD:
  - Busy=1. Each cycle the datapath computes {c,s} = A_w + B'_w + carry, where w is the current index.
  - At the edge: accumulator word w <= s; carry <= c; index <= index+1.
  - Arithmetic is 17 bits wide, unsigned, with no saturation.
  - When index==WORDS-1, the edge instead loads Sum <= full accumulator (including the final word) and CO <= c, then goes to DONE.
  - The index wraps to 0 on leaving ADD.
- DONE:
  - Busy=1, Done=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency:
  - Start accepted at edge k; Done is high during the cycle after edge k+WORDS.
  - Sum and CO are valid from that cycle onward.
  - Sum and CO hold their value until the next operation completes; they never show partial results.
- Start while Busy=1 (ADD or DONE) is ignored and not queued.
- If Start is held continuously high, operations run back-to-back with period WORDS+2 cycles.
- Changes on A, B or Sub after acceptance have no effect on the operation in progress.
- Reset asserted mid-operation aborts the operation: no Done pulse is produced and Sum/CO return to 0.
- Done and Busy are registered (state-decoded), with no combinational path from Start.

Optional Feature:
- Macro: MULTIWORD_ADDER_CTRL_SUB_EN.
- Defined:
  - If the latched Sub=1, then B'_w = ~B_w and the initial carry=1, giving Sum = A - B modulo 2^(16*WORDS).
  - CO=1 means no borrow (A >= B unsigned).
  - If the latched Sub=0, the block adds as normal.
- Not defined:
  - The Sub port exists but is ignored: B'_w = B_w and the initial carry is always 0.

Test Plan (WORDS=4):
- Reset held 2 cycles, then released -> Sum=0, CO=0, Busy=0, Done=0; Done stays low for 20 idle cycles.
- A=0x0000_0000_0000_FFFF, B=0x1, Start pulse at edge k -> Busy high from k, Done high in the cycle after edge k+4; Sum=0x0000_0000_0001_0000, CO=0.
- A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 -> Sum=0, CO=1 (carry propagates through all 4 words).
- Start an add of 0x1234+0x1; pulse Start again with different operands during ADD -> the second request is ignored; exactly one Done; Sum=0x1235.
- Start an operation, assert Reset at the 2nd ADD cycle -> no Done; Sum=0, CO=0, state IDLE; a following add of 3+4 gives 7.
- With MULTIWORD_ADDER_CTRL_SUB_EN, Sub=1:
  - A=5, B=7 -> Sum=0xFFFF_FFFF_FFFF_FFFE, CO=0.
  - A=7, B=5 -> Sum=2, CO=1.
  - Without the macro, Sub=1 with A=5, B=7 -> Sum=12.

Source files
------------

// File: rtl/multiword_adder_ctrl_if.sv
// multiword_adder_ctrl_if: host-side start/operand/result handshake bundle for multiword_adder_ctrl
interface multiword_adder_ctrl_if #(
    parameter int WORDS = 4
);
    logic                  start;
    logic                  sub;
    logic [16*WORDS-1:0]   a;
    logic [16*WORDS-1:0]   b;
    logic [16*WORDS-1:0]   sum;
    logic                  co;
    logic                  busy;
    logic                  done;

    modport master (output start, sub, a, b, input sum, co, busy, done);
    modport slave  (input start, sub, a, b, output sum, co, busy, done);
endinterface

// File: rtl/multiword_adder_ctrl.sv
// multiword_adder_ctrl: WORDS x 16-bit multi-precision add through one shared 16-bit adder, LSW first.
// Define MULTIWORD_ADDER_CTRL_SUB_EN to enable A - B on sub=1; otherwise sub is ignored.
module multiword_adder_ctrl #(
    parameter int WORDS = 4
) (
    input logic                clk,
    input logic                rst,
    multiword_adder_ctrl_if.slave bus
);
    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;
    logic [W-1:0]  sum_r;
    logic          co_r;
    logic          busy_r;
    logic          done_r;
    logic [15:0]   a_w;
    logic [15:0]   b_w;
    logic [15:0]   s;
    logic          c;
    logic          carry_init;

`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
    logic          sub_r;
    assign carry_init = bus.sub;
`else
    logic          unused_sub;
    assign unused_sub = bus.sub;
    assign carry_init = 1'b0;
`endif

    // one word of the shared add-with-carry datapath, result merged into the accumulator image
    always_comb begin
        a_w = a_r[{idx, 4'h0} +: 16];
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
        b_w = sub_r ? ~b_r[{idx, 4'h0} +: 16] : b_r[{idx, 4'h0} +: 16];
`else
        b_w = b_r[{idx, 4'h0} +: 16];
`endif
        {c, s} = {1'b0, a_w} + {1'b0, b_w} + {16'h0, carry};
        acc_next = acc;
        acc_next[{idx, 4'h0} +: 16] = s;
    end

    // sequencer: latch operands, walk words LSW first, publish result and pulse done
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            sum_r  <= '0;
            co_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
            sub_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    busy_r <= bus.start;
                    if (bus.start) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b;
`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
                        sub_r <= bus.sub;
`endif
                        idx   <= '0;
                        carry <= carry_init;
                        state <= ADD;
                    end
                end
                ADD: begin
                    acc   <= acc_next;
                    carry <= c;
                    if (idx == IW'(WORDS - 1)) begin
                        sum_r  <= acc_next;
                        co_r   <= c;
                        idx    <= '0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.sum  = sum_r;
    assign bus.co   = co_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// tb_multiword_adder_ctrl: directed scoreboard bench for multiword_adder_ctrl (WORDS=4), honours MULTIWORD_ADDER_CTRL_SUB_EN
module tb_multiword_adder_ctrl;
    localparam int W = 4;
    localparam int N = 16 * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int passed = 0;
    int done_cnt = 0;
    logic [N:0] exp_q[$];
    logic [N:0] mon_exp;

    multiword_adder_ctrl_if #(.WORDS(W)) bus();
    multiword_adder_ctrl #(.WORDS(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N:0] act, input logic [N:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // monitor: every done pulse pops one expected {co,sum}
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_cnt++;
            chk("busy_with_done", bus.busy, 1);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got sum %h co %b with nothing expected", bus.sum, bus.co);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result", {bus.co, bus.sum}, mon_exp);
            end
        end
    end

    // waits up to 40 cycles for done (sel=0) or busy (sel=1) to equal val; n = negedges waited
    task automatic wait_sig(input string name, input bit sel, input logic val, output int n);
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((sel ? bus.busy : bus.done) === val) return;
        end
        checks++;
        $display("FAIL %s: timeout after 40 cycles, required %b", name, val);
        n = -1;
    endtask

    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub, input logic [N:0] exp);
        int n;
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.sub = sub;
        bus.start = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        wait_sig("op_done", 1'b0, 1'b1, n);
        if (n >= 0) chk("latency", n, W);
    endtask

    initial begin
        int n, n1, n2, d0;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", {bus.co, bus.sum}, 0);
        chk("reset_busy_done", {bus.busy, bus.done}, 0);
        repeat (20) @(negedge clk);
        chk("idle_no_done", done_cnt, 0);

        op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, {1'b0, 64'h0000_0000_0001_0000});
        op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, {1'b1, 64'h0});
        op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, {1'b1, 64'h0});
        op(64'h0001_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, {1'b0, 64'h0002_0000_0001_0000});

        // second start during ADD is ignored, operand changes after acceptance have no effect
        @(negedge clk);
        d0 = done_cnt;
        bus.a = 64'h1234;
        bus.b = 64'h1;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        exp_q.push_back({1'b0, 64'h1235});
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 64'hAAAA;
        bus.b = 64'h5555;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_sig("ignored_done", 1'b0, 1'b1, n);
        repeat (12) @(negedge clk);
        chk("one_done_only", done_cnt - d0, 1);

        // reset in the second ADD cycle aborts the operation
        @(negedge clk);
        bus.a = 64'h1111;
        bus.b = 64'h1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outputs", {bus.co, bus.sum}, 0);
        chk("abort_busy_done", {bus.busy, bus.done}, 0);
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        op(64'd3, 64'd4, 1'b0, {1'b0, 64'd7});

`ifdef MULTIWORD_ADDER_CTRL_SUB_EN
        op(64'd5, 64'd7, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        op(64'd7, 64'd5, 1'b1, {1'b1, 64'd2});
`else
        op(64'd5, 64'd7, 1'b1, {1'b0, 64'd12});
        op(64'd7, 64'd5, 1'b1, {1'b0, 64'd12});
`endif

        // start held high: back-to-back operations every WORDS+2 cycles
        @(negedge clk);
        bus.a = 64'd1;
        bus.b = 64'd2;
        bus.sub = 1'b0;
        bus.start = 1'b1;
        exp_q.push_back({1'b0, 64'd3});
        exp_q.push_back({1'b0, 64'd3});
        wait_sig("b2b_first_done", 1'b0, 1'b1, n);
        wait_sig("b2b_idle", 1'b1, 1'b0, n1);
        wait_sig("b2b_restart", 1'b1, 1'b1, n2);
        bus.start = 1'b0;
        wait_sig("b2b_second_done", 1'b0, 1'b1, n);
        if (n1 > 0 && n2 > 0 && n > 0) chk("b2b_period", n1 + n2 + n, W + 2);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
